// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM driving the shared-memory datapath,
// with an optional memory ready/valid handshake, optional bne and a sticky illegal-opcode halt.
module ucsbece154a_mc_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int BNE_EN        = 0,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [6:0]         op_i,
    input  logic [2:0]         funct3_i,
    input  logic               funct7b5_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_valid_o,
    output logic               PCWrite_o,
    output logic               AdrSrc_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic [1:0]         ResultSrc_o,
    output logic [2:0]         ALUControl_o,
    output logic [1:0]         ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [2:0]         ImmSrc_o,
    output logic               RegWrite_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWRITE = 4'd4,
        MEMWB    = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        ERROR    = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    state_t state, next_state;
    logic   illegal_q;
    logic   go;
    logic   mv, pcw, mw, irw, rw;
    logic   is_beq, is_bne;

    assign go     = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
    assign is_beq = (funct3_i == 3'b000);
    assign is_bne = (BNE_EN != 0) && (funct3_i == 3'b001);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            illegal_q <= illegal_q | (next_state == ERROR);
        end
    end

    always_comb begin
        next_state   = state;
        mv           = 1'b0;
        pcw          = 1'b0;
        mw           = 1'b0;
        irw          = 1'b0;
        rw           = 1'b0;
        AdrSrc_o     = 1'b0;
        ResultSrc_o  = 2'b00;
        ALUControl_o = 3'b000;
        ALUSrcA_o    = 2'b00;
        ALUSrcB_o    = 2'b00;
        case (state)
            FETCH: begin
                mv          = 1'b1;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                pcw         = go;
                irw         = go;
                if (go) next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
                case (op_i)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_BR:        next_state = (is_beq || is_bne) ? BRANCH : ERROR;
                    OP_JAL:       next_state = JAL;
                    OP_LUI:       next_state = LUI;
                    default:      next_state = ERROR;
                endcase
            end
            MEMADR: begin
                ALUSrcA_o  = 2'b10;
                ALUSrcB_o  = 2'b01;
                next_state = (op_i == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mv       = 1'b1;
                AdrSrc_o = 1'b1;
                if (go) next_state = MEMWB;
            end
            MEMWRITE: begin
                mv       = 1'b1;
                AdrSrc_o = 1'b1;
                mw       = 1'b1;
                if (go) next_state = FETCH;
            end
            MEMWB: begin
                ResultSrc_o = 2'b01;
                rw          = 1'b1;
                next_state  = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcA_o  = 2'b10;
                ALUSrcB_o  = (state == EXECI) ? 2'b01 : 2'b00;
                next_state = ALUWB;
                case (funct3_i)
                    3'b000:  ALUControl_o = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl_o = 3'b101;
                    3'b110:  ALUControl_o = 3'b011;
                    3'b111:  ALUControl_o = 3'b010;
                    default: next_state   = ERROR;
                endcase
            end
            ALUWB: begin
                rw         = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA_o    = 2'b10;
                ALUControl_o = 3'b001;
                pcw          = is_beq ? zero_i : (is_bne ? ~zero_i : 1'b0);
                next_state   = FETCH;
            end
            JAL: begin
                ALUSrcA_o  = 2'b01;
                ALUSrcB_o  = 2'b10;
                pcw        = 1'b1;
                next_state = ALUWB;
            end
            LUI: begin
                ResultSrc_o = 2'b11;
                rw          = 1'b1;
                next_state  = FETCH;
            end
            ERROR:   next_state = ERROR;
            default: next_state = ERROR;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_SW:   ImmSrc_o = 3'b001;
            OP_BR:   ImmSrc_o = 3'b010;
            OP_JAL:  ImmSrc_o = 3'b011;
            OP_LUI:  ImmSrc_o = 3'b100;
            default: ImmSrc_o = 3'b000;
        endcase
    end

    // Enables are gated by reset_n so nothing writes in the cycle reset asserts.
    assign mem_valid_o = mv  & reset_n;
    assign PCWrite_o   = pcw & reset_n;
    assign MemWrite_o  = mw  & reset_n;
    assign IRWrite_o   = irw & reset_n;
    assign RegWrite_o  = rw  & reset_n;
    assign illegal_o   = illegal_q;
    assign state_o     = STATE_W'(state);

endmodule

// File: doc/ucsbece154a_mc_controller.md
Name: ucsbece154a_mc_controller

Overview:
- Multicycle RISC-V control unit; successor to the single-cycle controller.
- Drives the shared-memory multicycle datapath (PC, OldPC, IR, Data, A, WriteData, ALUOut registers) through a Moore FSM.
- Adds a parametrised memory ready/valid handshake with wait states, optional bne support, and a sticky illegal-opcode halt.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal, lui.

Parameters:
MEM_HANDSHAKE, 1, 1 = honour mem_ready_i; 0 = treat mem_ready_i as constant 1 (fixed single-cycle memory)
BNE_EN, 0, 1 = branch state also handles bne (funct3 001)
STATE_W, 4, width of state_o debug port; must be >= 4

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
op_i  in  7  IR[6:0]
funct3_i  in  3  IR[14:12]
funct7b5_i  in  1  IR[30]
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory accepts or returns the current access this cycle
mem_valid_o  out  1  memory access requested
PCWrite_o  out  1  PC register enable
AdrSrc_o  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite_o  out  1  memory write strobe
IRWrite_o  out  1  IR and OldPC enable
ResultSrc_o  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
ALUControl_o  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcA_o  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A
ALUSrcB_o  out  2  ALU B select: 00 = WriteData, 01 = ImmExt, 10 = constant 4
ImmSrc_o  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U; decoded combinationally from op_i, independent of state
RegWrite_o  out  1  register file write enable
illegal_o  out  1  sticky unsupported-opcode flag
state_o  out  STATE_W  current state encoding (debug)

Behaviour:
- Reset:
  - State goes to FETCH and illegal_o clears to 0, asynchronously.
  - While reset_n = 0: PCWrite, IRWrite, RegWrite, MemWrite and mem_valid_o are forced to 0. Other outputs show FETCH values.
- Handshake rules:
  - "go" = mem_ready_i when MEM_HANDSHAKE = 1, otherwise 1.
  - mem_valid_o = 1 in FETCH, MEMREAD and MEMWRITE only.
  - While go = 0, the FSM holds its state and all control outputs stay stable.
- States and outputs (signals not listed are 0; select fields are don't-care but must drive 0):
  - FETCH:
    - Drives mem_valid, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALU add, ResultSrc = 10.
    - IRWrite and PCWrite are asserted only when go = 1.
    - Next state: DECODE on go, else FETCH.
  - DECODE:
    - ALUSrcA = 01, ALUSrcB = 01, add (computes the branch/jal target).
    - Next state by opcode:
      - lw or sw -> MEMADR
      - R-type -> EXECR
      - I-type ALU -> EXECI
      - beq (or bne when BNE_EN = 1) -> BRANCH
      - jal -> JAL
      - lui -> LUI
      - anything else -> ERROR
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. Next state: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD:
    - Drives mem_valid, AdrSrc = 1, ResultSrc = 00.
    - Next state: MEMWB on go.
  - MEMWRITE:
    - Drives mem_valid, AdrSrc = 1, ResultSrc = 00.
    - MemWrite is held at 1 for every cycle of the state.
    - Next state: FETCH on go.
  - MEMWB: ResultSrc = 01, RegWrite. Next state: FETCH.
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALU decode. Next state: ALUWB.
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALU decode. Next state: ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite. Next state: FETCH.
  - BRANCH:
    - ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00.
    - PCWrite = zero_i for beq; PCWrite = !zero_i for bne when BNE_EN = 1.
    - Next state: FETCH.
  - JAL:
    - ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite.
    - Next state: ALUWB, which writes OldPC + 4.
  - LUI: ResultSrc = 11, RegWrite. Next state: FETCH.
  - ERROR:
    - illegal_o is set to 1. All enables are 0.
    - Terminal state; only reset_n leaves it.
- ALU decode (EXECR/EXECI):
  - funct3 000: sub if (funct7b5_i & op_i[5]), else add.
  - funct3 010: slt. funct3 110: or. funct3 111: and.
  - Any other funct3 in these states -> ERROR on the next edge instead of ALUWB. ALUControl is 000 in that cycle.
- Latency in cycles, measured from the FETCH-complete edge with go = 1 on every access:
  - lw 5, sw 4, R/I-type 4, branch 3, jal 4, lui 3.
  - Each go = 0 cycle adds exactly 1.
- Asserting reset_n low mid-instruction aborts the instruction immediately. No partial MemWrite or RegWrite occurs after reset asserts.

Test Plan:
- Reset: reset_n = 0 during MEMWRITE with MemWrite = 1 -> MemWrite_o = 0 immediately; after release, state = FETCH and illegal_o = 0.
- lw (op 0000011), go always 1 -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 only in MEMWB with ResultSrc = 01.
- sw with mem_ready_i low for 3 cycles in MEMWRITE -> MemWrite_o held 1 for 4 cycles, FSM returns to FETCH after the ready cycle; with MEM_HANDSHAKE = 0 the wait is ignored and MemWrite lasts 1 cycle.
- beq with zero_i = 1 -> PCWrite = 1 in BRANCH; with zero_i = 0 -> PCWrite = 0. bne (funct3 001, BNE_EN = 1), zero_i = 0 -> PCWrite = 1.
- sub R-type (funct7b5 = 1, funct3 000) -> ALUControl = 001 in EXECR; addi with funct7b5 = 1 -> 000. jal -> PCWrite in JAL, then ALUWB writes. lui -> ResultSrc = 11, ImmSrc = 100.
- Opcode 0x7F -> ERROR after DECODE, illegal_o = 1, no further PCWrite or IRWrite until reset.
